// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the stall controller: D/E/M instruction words in,
// stall/flush and mult/div status out.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      instrD;
  logic [31:0]      instrE;
  logic [31:0]      instrM;
  logic             stall;
  logic             flushE;
  logic             md_busy;
  logic [3:0]       md_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output instrD, instrE, instrM,
    input  stall, flushE, md_busy, md_cnt, stall_cnt
  );

  modport slave (
    input  instrD, instrE, instrM,
    output stall, flushE, md_busy, md_cnt, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall controller for the 5-stage MIPS pipeline: load-use and
// branch-operand hazard detection plus mult/div busy sequencing.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_stall_ctrl_if.slave bus
);

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  function automatic logic is_rtype(input logic [31:0] i);
    return (i[31:26] == OP_R) && (i != '0);
  endfunction

  function automatic logic reads_rs(input logic [31:0] i);
    return is_rtype(i) ||
           (i[31:26] inside {OP_BEQ, OP_BNE, OP_SW, OP_ORI, OP_ADDIU, OP_LW});
  endfunction

  function automatic logic reads_rt(input logic [31:0] i);
    return is_rtype(i) || (i[31:26] inside {OP_BEQ, OP_BNE, OP_SW});
  endfunction

  function automatic logic branch_use(input logic [31:0] i);
    return (i[31:26] inside {OP_BEQ, OP_BNE}) ||
           ((i[31:26] == OP_R) && (i[5:0] == FN_JR));
  endfunction

  function automatic logic [4:0] dest_reg(input logic [31:0] i);
    logic [4:0] d;
    d = '0;
    if (i[31:26] == OP_R) begin
      if (i[5:0] inside {6'h00, [6'h20:6'h25], 6'h2A, 6'h2B, 6'h10, 6'h12})
        d = i[15:11];
    end else if (i[31:26] inside {OP_ORI, OP_ADDIU, OP_LUI, OP_LW}) begin
      d = i[20:16];
    end
    return d;
  endfunction

  // True when i sources register r; r = 0 never counts as a dependency.
  function automatic logic uses_reg(input logic [31:0] i, input logic [4:0] r);
    return (r != '0) &&
           ((reads_rs(i) && (i[25:21] == r)) || (reads_rt(i) && (i[20:16] == r)));
  endfunction

  function automatic logic is_lw(input logic [31:0] i);
    return i[31:26] == OP_LW;
  endfunction

  function automatic logic is_md(input logic [31:0] i);
    return (i[31:26] == OP_R) && (i[5:0] inside {[6'h18:6'h1B], [6'h10:6'h13]});
  endfunction

  function automatic logic is_mult(input logic [31:0] i);
    return (i[31:26] == OP_R) && (i[5:0] inside {6'h18, 6'h19});
  endfunction

  function automatic logic is_div(input logic [31:0] i);
    return (i[31:26] == OP_R) && (i[5:0] inside {6'h1A, 6'h1B});
  endfunction

  logic [3:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [4:0]       wE, wM;
  logic             md_start, load_use, br_e, br_m, md_haz, stall;

  always_comb begin
    wE       = dest_reg(bus.instrE);
    wM       = dest_reg(bus.instrM);
    md_start = is_mult(bus.instrE) || is_div(bus.instrE);
    load_use = is_lw(bus.instrE) && uses_reg(bus.instrD, wE);
    br_e     = branch_use(bus.instrD) && uses_reg(bus.instrD, wE);
    br_m     = branch_use(bus.instrD) && is_lw(bus.instrM) && uses_reg(bus.instrD, wM);
    md_haz   = is_md(bus.instrD) && ((md_cnt_q != '0) || md_start);
    stall    = load_use || br_e || br_m || md_haz;
  end

  // A start in E always reloads, even if a previous operation is still counting.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (is_mult(bus.instrE))
      md_cnt_d = 4'(MULT_LAT);
    else if (is_div(bus.instrE))
      md_cnt_d = 4'(DIV_LAT);
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - 4'd1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall     = stall;
  assign bus.flushE    = stall;
  assign bus.md_busy   = (md_cnt_q != '0);
  assign bus.md_cnt    = md_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: per-cycle comparison against a
// rule-level model plus directed literal expectations.
module tb_hazard_stall_ctrl;
  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_stall_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // ---- behavioural model, from the instruction-class rules ----
  function automatic int m_dst(logic [31:0] i);
    int op, fn;
    op = int'(i[31:26]);
    fn = int'(i[5:0]);
    if (op == 0) begin
      if (fn == 0 || (fn >= 32 && fn <= 37) || fn == 42 || fn == 43 || fn == 16 || fn == 18)
        return int'(i[15:11]);
      return 0;
    end
    if (op == 9 || op == 13 || op == 15 || op == 35) return int'(i[20:16]);
    return 0;
  endfunction

  function automatic bit m_reads(logic [31:0] i, int r);
    int op, rs, rt;
    op = int'(i[31:26]);
    rs = int'(i[25:21]);
    rt = int'(i[20:16]);
    if (r == 0) return 0;
    if (op == 0 || op == 4 || op == 5 || op == 43) return (rs == r) || (rt == r);
    if (op == 9 || op == 13 || op == 35) return rs == r;
    return 0;
  endfunction

  function automatic bit m_branch(logic [31:0] i);
    int op;
    op = int'(i[31:26]);
    return op == 4 || op == 5 || (op == 0 && int'(i[5:0]) == 8);
  endfunction

  function automatic bit m_md(logic [31:0] i);
    int fn;
    fn = int'(i[5:0]);
    return int'(i[31:26]) == 0 && ((fn >= 24 && fn <= 27) || (fn >= 16 && fn <= 19));
  endfunction

  function automatic int m_lat(logic [31:0] i);
    int fn;
    fn = int'(i[5:0]);
    if (int'(i[31:26]) != 0) return 0;
    if (fn == 24 || fn == 25) return 5;
    if (fn == 26 || fn == 27) return 10;
    return 0;
  endfunction

  function automatic bit m_stall(logic [31:0] d, logic [31:0] e, logic [31:0] m, bit busy);
    int we, wm;
    we = m_dst(e);
    wm = m_dst(m);
    return (int'(e[31:26]) == 35 && m_reads(d, we)) ||
           (m_branch(d) && m_reads(d, we)) ||
           (m_branch(d) && int'(m[31:26]) == 35 && m_reads(d, wm)) ||
           (m_md(d) && (busy || m_lat(e) != 0));
  endfunction

  // Model state: edges since reset, last mult/div start and total stall edges.
  int edge_no = 0, st_edge = 0, st_lat = 0, stalls = 0;

  function automatic int exp_md();
    int r;
    r = st_lat - (edge_no - st_edge);
    return (r > 0) ? r : 0;
  endfunction

  function automatic int exp_sc();
    return (stalls > SAT) ? SAT : stalls;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_no = 0; st_edge = 0; st_lat = 0; stalls = 0;
    end else begin
      if (m_stall(bus.instrD, bus.instrE, bus.instrM, exp_md() != 0)) stalls++;
      edge_no++;
      if (m_lat(bus.instrE) != 0) begin
        st_edge = edge_no;
        st_lat  = m_lat(bus.instrE);
      end
    end
  end

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit s;
    s = m_stall(bus.instrD, bus.instrE, bus.instrM, exp_md() != 0);
    check("cyc_stall",     int'(bus.stall),     int'(s));
    check("cyc_flushE",    int'(bus.flushE),    int'(s));
    check("cyc_md_busy",   int'(bus.md_busy),   int'(exp_md() != 0));
    check("cyc_md_cnt",    int'(bus.md_cnt),    exp_md());
    check("cyc_stall_cnt", int'(bus.stall_cnt), exp_sc());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] d, logic [31:0] e, logic [31:0] m);
    bus.instrD = d;
    bus.instrE = e;
    bus.instrM = m;
  endtask

  initial begin
    logic [31:0] lw8, addu98, lui8, addu5, beq50, beq05, lw5, lw0, addu0, mult, divi, mflo, mfhi, jr5;
    lw8    = itype(35, 0, 8, 0);
    addu98 = rtype(8, 1, 9, 33);
    lui8   = itype(15, 0, 8, 4);
    addu5  = rtype(1, 2, 5, 33);
    addu0  = rtype(1, 2, 0, 33);
    beq50  = itype(4, 5, 0, 3);
    beq05  = itype(4, 0, 5, 3);
    lw5    = itype(35, 0, 5, 0);
    lw0    = itype(35, 0, 0, 0);
    mult   = rtype(1, 2, 0, 24);
    divi   = rtype(1, 2, 0, 26);
    mflo   = rtype(0, 0, 3, 18);
    mfhi   = rtype(0, 0, 3, 16);
    jr5    = rtype(5, 0, 0, 8);
    drive('0, '0, '0);

    #1 rst = 1'b0;
    #1;
    check("rst_md_cnt",    int'(bus.md_cnt),    0);
    check("rst_md_busy",   int'(bus.md_busy),   0);
    check("rst_stall_cnt", int'(bus.stall_cnt), 0);
    cyc();
    rst = 1'b1;
    cyc();

    // Load-use
    drive(addu98, lw8, '0);
    #1;
    check("lu_stall",  int'(bus.stall),  1);
    check("lu_flushE", int'(bus.flushE), 1);
    cyc();
    check("lu_count", int'(bus.stall_cnt), 1);
    drive(addu98, '0, '0);
    #1;
    check("lu_clear", int'(bus.stall), 0);
    drive(lui8, lw8, '0);
    #1;
    check("lu_lui", int'(bus.stall), 0);
    cyc();
    check("lu_lui_count", int'(bus.stall_cnt), 1);

    // Branch hazards
    drive(beq50, addu5, '0);
    #1 check("br_e", int'(bus.stall), 1);
    drive(jr5, addu5, '0);
    #1 check("br_jr", int'(bus.stall), 1);
    drive(beq05, '0, lw5);
    #1 check("br_m", int'(bus.stall), 1);
    drive(beq05, '0, addu5);
    #1 check("br_m_nonload", int'(bus.stall), 0);
    drive(beq05, addu0, '0);
    #1 check("br_e_r0", int'(bus.stall), 0);
    drive(beq05, '0, lw0);
    #1 check("br_m_r0", int'(bus.stall), 0);
    cyc();
    drive('0, '0, '0);
    cyc();

    // Mult countdown with mflo waiting in D
    drive(mflo, mult, '0);
    #1;
    check("mul_stall0", int'(bus.stall),  1);
    check("mul_cnt0",   int'(bus.md_cnt), 0);
    cyc();
    drive(mflo, '0, '0);
    for (int i = 0; i < 5; i++) begin
      check("mul_cnt",   int'(bus.md_cnt),  5 - i);
      check("mul_busy",  int'(bus.md_busy), 1);
      check("mul_stall", int'(bus.stall),   1);
      cyc();
    end
    check("mul_done_cnt",   int'(bus.md_cnt),  0);
    check("mul_done_busy",  int'(bus.md_busy), 0);
    check("mul_done_stall", int'(bus.stall),   0);

    // Div countdown
    drive(mflo, divi, '0);
    cyc();
    drive(mflo, '0, '0);
    for (int i = 0; i < 10; i++) begin
      check("div_cnt",   int'(bus.md_cnt), 10 - i);
      check("div_stall", int'(bus.stall),  1);
      cyc();
    end
    check("div_done_cnt",   int'(bus.md_cnt), 0);
    check("div_done_stall", int'(bus.stall),  0);

    // Async reset mid-countdown
    drive('0, divi, '0);
    cyc();
    drive('0, '0, '0);
    cyc(); cyc(); cyc();
    check("ar_pre_cnt", int'(bus.md_cnt), 7);
    #2 rst = 1'b0;
    #1;
    check("ar_cnt",       int'(bus.md_cnt),    0);
    check("ar_busy",      int'(bus.md_busy),   0);
    check("ar_stall_cnt", int'(bus.stall_cnt), 0);
    #2 rst = 1'b1;
    drive(mfhi, addu5, '0);
    #1 check("ar_mfhi", int'(bus.stall), 0);
    cyc();
    check("ar_mfhi_cnt", int'(bus.stall_cnt), 0);

    // Saturation of the stall counter
    drive(addu98, lw8, '0);
    repeat (20) cyc();
    check("sat_20", int'(bus.stall_cnt), SAT);
    cyc();
    check("sat_hold", int'(bus.stall_cnt), SAT);
    drive('0, '0, '0);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall controller for the 5-stage MIPS pipeline.
- Decodes the instructions held in the D, E and M pipeline registers and detects load-use and branch-operand hazards.
- Sequences a multi-cycle mult/div unit with an internal busy counter.
- Drives one stall that freezes PC and IF/ID, plus a flush that injects a nop into ID/EX.

Parameters:
- MULT_LAT, 5, busy cycles after mult/multu issue in E.
- DIV_LAT, 10, busy cycles after div/divu issue in E.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- instrD  in  32  instruction in IF/ID register.
- instrE  in  32  instruction in ID/EX register.
- instrM  in  32  instruction in EX/MEM register.
- stall  out  1  freeze PC and IF/ID.
- flushE  out  1  clear ID/EX next edge; equals stall.
- md_busy  out  1  mult/div unit busy.
- md_cnt  out  4  remaining busy cycles.
- stall_cnt  out  CNT_W  total stall cycles, saturating.

Behaviour:
- Decode: op = instr[31:26], fn = instr[5:0], rs = [25:21], rt = [20:16], rd = [15:11].
- D source use:
  - Reads rs and rt: op 0 (R-type), beq (0x04), bne (0x05), sw (0x2B).
  - Reads rs only: ori (0x0D), addiu (0x09), lw (0x23).
  - Reads nothing: lui (0x0F), j (0x02), jal (0x03), all-zero nop.
  - Branches (beq/bne) and jr (op 0, fn 0x08) need operands in D ("branch-use").
  - All other D instructions need operands in E.
- Destination of an instruction, wE or wM:
  - rd for R-type fn in {0x00, 0x20–0x25, 0x2A, 0x2B, 0x10 mfhi, 0x12 mflo}.
  - rt for ori, addiu, lui, lw.
  - Otherwise none. jal is never a hazard source.
  - Destination 0 is never a hazard.
- Stall conditions (combinational; OR of all):
  - Load-use: instrE is lw, wE ≠ 0, and D reads wE.
  - Branch-E: D is branch-use, instrE writes wE ≠ 0, and D reads wE.
  - Branch-M: D is branch-use, instrM is lw, wM ≠ 0, and D reads wM.
  - MD: D is an md-instruction (op 0, fn in {0x18–0x1B, 0x10–0x13}) and (md_busy or instrE is mult/div start).
- md counter:
  - On each rising edge where instrE is mult/multu, load MULT_LAT; div/divu loads DIV_LAT.
  - Otherwise decrement if nonzero; holds at 0.
  - md_busy = (md_cnt ≠ 0).
  - A start while busy cannot occur (MD stall); if forced, the new load wins.
  - Timing: mult in E at edge k gives md_busy = 1 for exactly MULT_LAT cycles after edge k.
- stall_cnt:
  - Increments on every edge where stall = 1.
  - Saturates at all-ones; no wrap.
- Reset:
  - rst = 0 asynchronously clears md_cnt and stall_cnt, mid-countdown included.
  - md_busy = 0 during reset.
  - stall and flushE are combinational and may be 1 during reset if inputs demand it; pipeline registers are also under reset, so this is harmless.
- No other state. Outputs change only on clk edges (counters) or input changes (stall).

Test Plan:
- Reset: rst = 0 at any time → md_cnt = 0, md_busy = 0, stall_cnt = 0 immediately, without a clk edge.
- Load-use:
  - instrE = lw $8,0($0), instrD = addu $9,$8,$1 → stall = flushE = 1 for one cycle; stall_cnt increments by 1.
  - Same with instrD = lui $8 → stall = 0.
- Branch hazards:
  - instrE = addu $5,$1,$2, instrD = beq $5,$0 → stall = 1.
  - instrM = lw $5, instrD = beq $0,$5 → stall = 1.
  - Destination $0 in either case → stall = 0.
- Mult/div:
  - mult in E at edge 0 → md_busy = 1 for cycles 1–5; md_cnt reads 5, 4, 3, 2, 1, 0.
  - instrD = mflo during cycles 0–5 → stall = 1; stall drops on the cycle md_cnt = 0.
  - div gives the same pattern over 10 cycles.
- Async reset mid-operation: rst = 0 while md_cnt = 7 after a div → md_cnt = 0 asynchronously; after release, instrD = mfhi with a non-md instrE → stall = 0.
- Saturation: with CNT_W = 4, hold a load-use stall for 20 cycles → stall_cnt = 15 and stays at 15.
